// File: rtl/pacman_pkg.sv
// pacman_pkg: shared direction codes, FSM states and direction helpers
package pacman_pkg;
    typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MOVING, ST_BLOCKED} state_t;
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction
endpackage

// File: rtl/pacman_dir_control_press_encoder.sv
// press_encoder: priority-encodes four press pulses (UP > RIGHT > DOWN > LEFT)
module press_encoder
    import pacman_pkg::*;
(
    input  logic       up,
    input  logic       right,
    input  logic       down,
    input  logic       left,
    output logic       valid,
    output logic [1:0] code
);
    assign valid = up | right | down | left;
    assign code  = up ? DIR_UP : right ? DIR_RIGHT : down ? DIR_DOWN : DIR_LEFT;
endmodule

// File: rtl/pacman_dir_control.sv
// pacman_dir_control: turns press pulses into a held direction with a queued, expiring pre-turn
module pacman_dir_control
    import pacman_pkg::*;
#(
    parameter int QUEUE_TICKS = 8,
    parameter int RESET_DIR   = 3
) (
    input  logic       d_clk,
    input  logic       rst_n,
    input  logic       press_up,
    input  logic       press_right,
    input  logic       press_down,
    input  logic       press_left,
    input  logic       move_tick,
    input  logic [3:0] turn_ok,
    output logic [1:0] dir_out,
    output logic       moving,
    output logic       pending_valid,
    output logic       turn_pulse
);
    localparam int AW = QUEUE_TICKS > 1 ? $clog2(QUEUE_TICKS) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(QUEUE_TICKS - 1);

    state_t          st, st_n;
    logic [1:0]      dir, dir_n, pend, pend_n, ep, p_code;
    logic            pv, pv_n, epv, p_vld, rev, same, take, chg;
    logic [AW-1:0]   age, age_n, ea;

    press_encoder u_enc (
        .up    (press_up),
        .right (press_right),
        .down  (press_down),
        .left  (press_left),
        .valid (p_vld),
        .code  (p_code)
    );

    // a same-cycle press replaces the held turn before the tick is evaluated
    assign rev  = st == ST_MOVING && p_vld && p_code == opposite(dir);
    assign same = st == ST_MOVING && p_vld && p_code == dir;
    assign epv  = p_vld ? !same : pv;
    assign ep   = p_vld ? p_code : pend;
    assign ea   = p_vld ? '0 : age;
    assign take = move_tick && epv && turn_ok[ep];

    always_comb begin
        st_n   = st;
        dir_n  = dir;
        pend_n = ep;
        pv_n   = epv;
        age_n  = ea;
        if (rev) begin
            dir_n = p_code;
            pv_n  = 1'b0;
            age_n = '0;
        end else if (take) begin
            dir_n = ep;
            pv_n  = 1'b0;
            age_n = '0;
            st_n  = ST_MOVING;
        end else if (move_tick) begin
            st_n = st == ST_IDLE ? ST_IDLE : turn_ok[dir] ? ST_MOVING : ST_BLOCKED;
            if (epv) begin
                pv_n  = ea != AGE_MAX;
                age_n = ea == AGE_MAX ? '0 : ea + 1'b1;
            end
        end
    end

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            dir        <= 2'(RESET_DIR);
            pend       <= '0;
            pv         <= 1'b0;
            age        <= '0;
            chg        <= 1'b0;
            turn_pulse <= 1'b0;
            moving     <= 1'b0;
        end else begin
            st         <= st_n;
            dir        <= dir_n;
            pend       <= pend_n;
            pv         <= pv_n;
            age        <= age_n;
            chg        <= dir_n != dir;
            turn_pulse <= chg;
            moving     <= st_n == ST_MOVING;
        end
    end

    assign dir_out       = dir;
    assign pending_valid = pv;
endmodule

// File: tb/tb_pacman_dir_control.sv
// tb_pacman_dir_control: randomized scoreboard bench against a tick-countdown reference model
module tb_pacman_dir_control;
    localparam int QT = 8;

    logic       d_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pu = 1'b0, pr = 1'b0, pd = 1'b0, pl = 1'b0, move_tick = 1'b0;
    logic [3:0] turn_ok = 4'b0;
    logic [1:0] dir_out;
    logic       moving, pending_valid, turn_pulse;

    typedef struct packed {
        logic [1:0] dir;
        logic       mv;
        logic       pv;
        logic       tp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   m_dir, m_prev, m_mode, m_left;
    int   m_q[$];

    always #5 d_clk = ~d_clk;

    pacman_dir_control #(.QUEUE_TICKS(QT), .RESET_DIR(3)) dut (
        .d_clk         (d_clk),
        .rst_n         (rst_n),
        .press_up      (pu),
        .press_right   (pr),
        .press_down    (pd),
        .press_left    (pl),
        .move_tick     (move_tick),
        .turn_ok       (turn_ok),
        .dir_out       (dir_out),
        .moving        (moving),
        .pending_valid (pending_valid),
        .turn_pulse    (turn_pulse)
    );

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    // mode: 0 idle, 1 moving, 2 blocked; m_left counts ticks the queued turn may still survive
    task automatic model_reset();
        m_dir  = 3;
        m_prev = 3;
        m_mode = 0;
        m_left = 0;
        m_q.delete();
    endtask

    task automatic step(input logic [3:0] pb, input logic tk, input logic [3:0] ok);
        int   code;
        exp_t e;
        @(negedge d_clk);
        {pl, pd, pr, pu} = pb;
        move_tick = tk;
        turn_ok = ok;
        code = -1;
        for (int i = 3; i >= 0; i--) if (pb[i]) code = i;
        e.tp = m_dir != m_prev;
        m_prev = m_dir;
        if (m_mode == 1 && code >= 0 && code == (m_dir ^ 2)) begin
            m_dir = code;
            m_q.delete();
        end else begin
            if (code >= 0) begin
                m_q.delete();
                if (!(m_mode == 1 && code == m_dir)) begin
                    m_q.push_back(code);
                    m_left = QT;
                end
            end
            if (tk) begin
                if (m_q.size() > 0 && ok[m_q[0]]) begin
                    m_dir = m_q[0];
                    m_q.delete();
                    m_mode = 1;
                end else begin
                    if (m_mode != 0) m_mode = ok[m_dir] ? 1 : 2;
                    if (m_q.size() > 0) begin
                        m_left--;
                        if (m_left == 0) m_q.delete();
                    end
                end
            end
        end
        e.dir = 2'(m_dir);
        e.mv  = m_mode == 1;
        e.pv  = m_q.size() > 0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge d_clk);
        {pl, pd, pr, pu} = 4'b0;
        move_tick = 1'b0;
        turn_ok = 4'b0;
        rst_n = 1'b0;
        #1;
        check("rst_dir", dir_out, 3);
        check("rst_pending", pending_valid, 0);
        check("rst_moving", moving, 0);
        check("rst_pulse", turn_pulse, 0);
        repeat (2) @(negedge d_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge d_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dir_out", dir_out, e.dir);
                check("moving", moving, e.mv);
                check("pending_valid", pending_valid, e.pv);
                check("turn_pulse", turn_pulse, e.tp);
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        step(4'b0000, 1, 4'b1000);
        step(4'b1000, 0, 4'b0000);
        step(4'b0000, 1, 4'b1000);
        step(4'b0001, 0, 4'b0000);
        repeat (3) step(4'b0000, 1, 4'b1000);
        step(4'b0000, 1, 4'b1001);
        repeat (2) step(4'b0000, 0, 4'b0000);
        step(4'b1000, 1, 4'b1000);
        step(4'b0010, 0, 4'b0000);
        repeat (2) step(4'b0000, 0, 4'b0000);
        step(4'b1000, 0, 4'b0000);
        step(4'b0100, 0, 4'b0000);
        repeat (8) step(4'b0000, 1, 4'b1000);
        step(4'b0000, 1, 4'b1100);
        step(4'b0001, 1, 4'b0001);
        step(4'b0000, 1, 4'b0100);
        step(4'b0010, 1, 4'b0010);
        step(4'b1001, 0, 4'b0000);
        step(4'b0000, 0, 4'b0000);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000,
                 $urandom_range(0, 2) == 0, 4'($urandom));
        end
        step(4'b0000, 0, 4'b0000);
        @(posedge d_clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
